// File: rtl/seg7_pkg.sv
// Shared seven-segment display codes, formatter state encoding and digit formatting
// for the accelerometer display path.
package seg7_pkg;

    localparam logic [3:0]  CODE_BLANK = 4'ha;
    localparam logic [3:0]  CODE_MINUS = 4'hf;
    localparam logic [3:0]  CODE_DOT   = 4'hb;
    localparam int          BCD_DIGITS = 3;
    localparam logic [15:0] DIG_RESET  = {CODE_BLANK, CODE_BLANK, CODE_BLANK, 4'h0};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

    // Blanking runs from the left; units always shows so a zero sample still reads "0".
    function automatic logic [15:0] formatDigits(input logic negative,
                                                 input logic [4*BCD_DIGITS-1:0] bcd,
                                                 input logic blankLz);
        logic [3:0] hund;
        logic [3:0] tens;
        hund = bcd[11:8];
        tens = bcd[7:4];
        if (blankLz && (bcd[11:8] == 4'h0)) begin
            hund = CODE_BLANK;
            if (bcd[7:4] == 4'h0) begin
                tens = CODE_BLANK;
            end
        end
        return {(negative ? CODE_MINUS : CODE_BLANK), hund, tens, bcd[3:0]};
    endfunction

endpackage

// File: rtl/accel_bcd_formatter_if.sv
// Sample-in / digits-out handshake between the G-sensor axis register and the
// seven-segment digit formatter.
interface accel_bcd_formatter_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              busy;
    logic [15:0]       dig;
    logic              digValid;

    modport master (output data, valid, input busy, dig, digValid);
    modport slave  (input data, valid, output busy, dig, digValid);
endinterface

// File: rtl/accel_bcd_formatter_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift
// so that it carries correctly into the next decimal digit.
module bcd_add3_cell (
    input  logic [3:0] nibbleIn,
    output logic [3:0] nibbleOut
);
    assign nibbleOut = (nibbleIn >= 4'd5) ? (nibbleIn + 4'd3) : nibbleIn;
endmodule

// File: rtl/accel_bcd_formatter.sv
// Converts one signed axis sample into {sign,hundreds,tens,units} display codes
// using a bit-serial double-dabble, one magnitude bit per clock.
module accel_bcd_formatter
    import seg7_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    accel_bcd_formatter_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * BCD_DIGITS;

    stateT             state;
    logic              sign;
    logic [DATA_W-1:0] mag;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcdAdj;
    logic [CNT_W-1:0]  bitCount;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : gAdd3
        bcd_add3_cell uCell (
            .nibbleIn  (bcd[4*g +: 4]),
            .nibbleOut (bcdAdj[4*g +: 4])
        );
    end

    // Two's-complement negate in DATA_W bits, so the most negative sample maps to
    // 2^(DATA_W-1) exactly as an unsigned magnitude.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= IDLE;
            sign         <= 1'b0;
            mag          <= '0;
            bcd          <= '0;
            bitCount     <= '0;
            bus.busy     <= 1'b0;
            bus.dig      <= DIG_RESET;
            bus.digValid <= 1'b0;
        end else begin
            bus.digValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        sign     <= bus.data[DATA_W-1];
                        mag      <= bus.data[DATA_W-1] ? (~bus.data + DATA_W'(1)) : bus.data;
                        bcd      <= '0;
                        bitCount <= CNT_W'(DATA_W);
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd      <= (bcdAdj << 1) | BCD_W'(mag[DATA_W-1]);
                    mag      <= mag << 1;
                    bitCount <= bitCount - CNT_W'(1);
                    if (bitCount == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.dig      <= formatDigits(sign, bcd, BLANK_LZ);
                    bus.digValid <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_bcd_formatter.sv
// Directed and exhaustive checks of accel_bcd_formatter with blanking on (dutA)
// and off (dutB); expected digits come from a decimal model via a scoreboard queue.
module tb_accel_bcd_formatter;
    import seg7_pkg::*;

    localparam int DATA_W  = 10;
    localparam int LATENCY = DATA_W + 1;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    accel_bcd_formatter_if #(.DATA_W(DATA_W)) busA ();
    accel_bcd_formatter_if #(.DATA_W(DATA_W)) busB ();

    accel_bcd_formatter #(.DATA_W(DATA_W), .BLANK_LZ(1'b1)) dutA (
        .iCLK   (clk),
        .iRST_N (rstN),
        .bus    (busA)
    );

    accel_bcd_formatter #(.DATA_W(DATA_W), .BLANK_LZ(1'b0)) dutB (
        .iCLK   (clk),
        .iRST_N (rstN),
        .bus    (busB)
    );

    always #5 clk = ~clk;

    int checks          = 0;
    int errors          = 0;
    int cycle           = 0;
    int acceptCycle     = 0;
    int validCountA     = 0;
    int validsExpectedA = 0;
    logic [15:0] expQA[$];
    logic [15:0] expQB[$];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (busA.digValid) begin
            validCountA <= validCountA + 1;
        end
    end

    // Decimal reference: digits by division, then sign and leading-zero blanking.
    function automatic logic [15:0] modelDig(input int value, input bit blank);
        int m;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        logic [3:0] s;
        m = (value < 0) ? -value : value;
        h = 4'(m / 100);
        t = 4'((m / 10) % 10);
        u = 4'(m % 10);
        s = (value < 0) ? 4'hf : 4'ha;
        if (blank && (h == 4'h0)) begin
            h = 4'ha;
            if (t == 4'h0) begin
                t = 4'ha;
            end
        end
        return {s, h, t, u};
    endfunction

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit raw, input int value);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            idle = raw ? !busB.busy : !busA.busy;
        end
        check("acceptReady", {15'b0, idle}, 16'h0001);
        if (raw) begin
            busB.data  = DATA_W'(value);
            busB.valid = 1'b1;
            expQB.push_back(modelDig(value, 1'b0));
        end else begin
            busA.data  = DATA_W'(value);
            busA.valid = 1'b1;
            expQA.push_back(modelDig(value, 1'b1));
            validsExpectedA++;
        end
        @(posedge clk);
        #1;
        acceptCycle = cycle;
        busA.valid  = 1'b0;
        busB.valid  = 1'b0;
    endtask

    task automatic checkOutput(input bit raw, input string tag);
        bit seen;
        logic [15:0] expected;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = raw ? busB.digValid : busA.digValid;
        end
        busA.valid = 1'b0;
        busB.valid = 1'b0;
        check({tag, "_seen"}, {15'b0, seen}, 16'h0001);
        if (seen) begin
            expected = 16'hxxxx;
            if (raw && expQB.size() > 0) expected = expQB.pop_front();
            if (!raw && expQA.size() > 0) expected = expQA.pop_front();
            check(tag, raw ? busB.dig : busA.dig, expected);
            check({tag, "_busy"}, {15'b0, raw ? busB.busy : busA.busy}, 16'h0000);
            check({tag, "_latency"}, 16'(cycle - acceptCycle), 16'(LATENCY));
        end
    endtask

    initial begin
        bit sawValid;
        busA.data  = '0;
        busA.valid = 1'b0;
        busB.data  = '0;
        busB.valid = 1'b0;

        repeat (2) @(negedge clk);
        check("resetDigA", busA.dig, 16'hAAA0);
        check("resetDigB", busB.dig, 16'hAAA0);
        check("resetValid", {15'b0, busA.digValid}, 16'h0000);
        check("resetBusy", {15'b0, busA.busy}, 16'h0000);
        rstN = 1'b1;

        applyStimulus(1'b0, 123);
        check("busyAfterAccept", {15'b0, busA.busy}, 16'h0001);
        checkOutput(1'b0, "pos123");
        check("pos123Literal", busA.dig, 16'hA123);

        applyStimulus(1'b0, -512);  checkOutput(1'b0, "neg512");
        applyStimulus(1'b0, 511);   checkOutput(1'b0, "pos511");
        applyStimulus(1'b0, 0);     checkOutput(1'b0, "zero");
        applyStimulus(1'b0, -7);    checkOutput(1'b0, "neg7");
        applyStimulus(1'b0, 105);   checkOutput(1'b0, "pos105");
        applyStimulus(1'b0, 10);    checkOutput(1'b0, "pos10");
        applyStimulus(1'b1, -7);    checkOutput(1'b1, "rawNeg7");
        check("rawNeg7Literal", busB.dig, 16'hF007);
        applyStimulus(1'b1, 0);     checkOutput(1'b1, "rawZero");

        // -45 is held on valid through the whole conversion of +45 and must be dropped.
        applyStimulus(1'b0, 45);
        busA.data  = DATA_W'(-45);
        busA.valid = 1'b1;
        checkOutput(1'b0, "heldPos45");
        check("heldPos45Literal", busA.dig, 16'hAA45);
        repeat (3) @(negedge clk);
        check("dropStaysIdle", {15'b0, busA.busy}, 16'h0000);
        check("dropDigHeld", busA.dig, 16'hAA45);
        applyStimulus(1'b0, -45);   checkOutput(1'b0, "resendNeg45");

        applyStimulus(1'b0, 300);
        repeat (4) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        check("midResetDig", busA.dig, 16'hAAA0);
        check("midResetValid", {15'b0, busA.digValid}, 16'h0000);
        check("midResetBusy", {15'b0, busA.busy}, 16'h0000);
        void'(expQA.pop_back());
        validsExpectedA--;
        @(negedge clk);
        rstN = 1'b1;
        sawValid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            sawValid |= busA.digValid;
        end
        check("noValidAfterReset", {15'b0, sawValid}, 16'h0000);
        applyStimulus(1'b0, 9);     checkOutput(1'b0, "pos9");
        check("pos9Literal", busA.dig, 16'hAAA9);

        for (int v = -(1 << (DATA_W - 1)); v < (1 << (DATA_W - 1)); v++) begin
            applyStimulus(1'b0, v);
            checkOutput(1'b0, "sweep");
        end

        repeat (3) @(negedge clk);
        check("validCount", 16'(validCountA), 16'(validsExpectedA));
        check("queueEmpty", 16'(expQA.size() + expQB.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
